// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory responder.
//   state_t      : responder FSM states (IDLE, BUSY, DONE)
//   ERR_MISALIGN : memErr bit flagging a non-word-aligned address
//   ERR_RANGE    : memErr bit flagging an address beyond the array
//   CNT_W        : width of the latency countdown counter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_RANGE    = 1;
  localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM, DEPTH_WORDS x 32, registered read.
// Ports:
//   clk   in  : clock
//   en    in  : access enable (read always, write when we)
//   we    in  : write enable
//   addr  in  : word index
//   wdata in  : write data
//   rdata out : read data, valid the cycle after an enabled access
// Contents are not reset.
module dmem_array #(
  parameter int unsigned  DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency responder for the core's data port.
// Accepts a read/write in IDLE, counts LATENCY BUSY cycles, performs the
// access on the latched request, then pulses memReady for one DONE cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   memoryRead    : read request
//   writeFlag     : write request (wins if both requests are high)
//   addressIn     : word-aligned byte address
//   dataOut       : write data
//   memoryDataIn  : read data, held until the next read completes
//   memReady      : one-cycle completion pulse
//   memErr        : [0] misaligned, [1] out of range; held until next completion
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (range checking of high address bits).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memoryRead,
  input  logic        writeFlag,
  input  logic [31:0] addressIn,
  input  logic [31:0] dataOut,
  output logic [31:0] memoryDataIn,
  output logic        memReady,
  output logic [1:0]  memErr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              accept, access;

  logic              op_write;
  logic [31:0]       addr_q, wdata_q;
  logic [1:0]        err_q, err_cur;
  logic [31:0]       data_hold, ram_rdata, rd_value;
  logic              ram_en, read_done;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (memoryRead || writeFlag) begin
          accept  = 1'b1;
          cnt_n   = CNT_W'(LATENCY - 1);
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          access  = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    err_cur = '0;
    err_cur[ERR_MISALIGN] = |addr_q[1:0];
`ifdef DMEM_BOUNDS_CHECK_EN
    err_cur[ERR_RANGE] = |addr_q[31:AW+2];
`endif
  end

`ifndef DMEM_BOUNDS_CHECK_EN
  logic unused_high;
  assign unused_high = |addr_q[31:AW+2];
`endif

  // Gating with rst keeps a write pending at a reset edge out of the array.
  assign ram_en = access && (err_cur == '0) && !rst;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (op_write),
    .addr (addr_q[AW+1:2]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // RAM output is only valid during DONE; it is captured into data_hold then
  // and bypassed straight to the port in that same cycle.
  assign read_done    = (state == DONE) && !op_write;
  assign rd_value     = (err_q != '0) ? '0 : ram_rdata;
  assign memoryDataIn = read_done ? rd_value : data_hold;
  assign memReady     = (state == DONE);
  assign memErr       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_write  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= '0;
      data_hold <= '0;
    end else begin
      if (accept) begin
        op_write <= writeFlag;
        addr_q   <= addressIn;
        wdata_q  <= dataOut;
      end
      if (access) begin
        err_q <= err_cur;
      end
      if (read_done) begin
        data_hold <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (defaults).
module tb_data_mem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memoryRead = 1'b0;
  logic        writeFlag = 1'b0;
  logic [31:0] addressIn = '0;
  logic [31:0] dataOut = '0;
  logic [31:0] memoryDataIn;
  logic        memReady;
  logic [1:0]  memErr;

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .memoryRead(memoryRead),
    .writeFlag(writeFlag),
    .addressIn(addressIn),
    .dataOut(dataOut),
    .memoryDataIn(memoryDataIn),
    .memReady(memReady),
    .memErr(memErr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [1024];
  logic [31:0] last_rd = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference behaviour: one access per request, write wins, errors suppress access.
  function automatic exp_t model(input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic mis, rng, ok;
    mis = (a[1:0] != 2'b00);
`ifdef DMEM_BOUNDS_CHECK_EN
    rng = ((a >> 12) != 0);
`else
    rng = 1'b0;
`endif
    ok = !mis && !rng;
    e.err = {rng, mis};
    e.cyc = 0;
    if (wr) begin
      if (ok) model_mem[a[11:2]] = d;
      e.data = last_rd;
    end else begin
      e.data  = ok ? model_mem[a[11:2]] : 32'h0;
      last_rd = e.data;
    end
    return e;
  endfunction

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int unsigned n;
    @(negedge clk);
    memoryRead = rd;
    writeFlag  = wr;
    addressIn  = a;
    dataOut    = d;
    e = model(wr, a, d);
    e.cyc = cyc + LAT + 1;
    sb.push_back(e);
    n = 0;
    while (!memReady && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!memReady) begin
      errors++;
      checks++;
      $display("FAIL timeout: no memReady for addr %h", a);
    end
    memoryRead = 1'b0;
    writeFlag  = 1'b0;
  endtask

  // Monitor: every completion pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (memReady) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_ready: cycle %0d, no response pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ready_cycle", cyc, e.cyc);
        chk("rdata", memoryDataIn, e.data);
        chk("err", {30'd0, memErr}, {30'd0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ready_seen;
    logic [31:0] a;
    int unsigned op;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, memReady}, 32'd0);
    chk("reset_rdata", memoryDataIn, 32'd0);
    chk("reset_err", {30'd0, memErr}, 32'd0);

    for (int unsigned i = 0; i < 16; i++) do_req(1'b0, 1'b1, 32'(i * 4), $urandom);

    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 1'b1, 32'h0, 32'h1);
    do_req(1'b0, 1'b1, 32'h4, 32'h2);
    do_req(1'b1, 1'b0, 32'h0, 32'h0);
    do_req(1'b1, 1'b0, 32'h4, 32'h0);
    do_req(1'b1, 1'b0, 32'h13, 32'h0);
    do_req(1'b0, 1'b1, 32'h22, 32'hAAAA);
    do_req(1'b1, 1'b0, 32'h20, 32'h0);
    do_req(1'b1, 1'b1, 32'h18, 32'h12345678);
    do_req(1'b1, 1'b0, 32'h18, 32'h0);
    do_req(1'b1, 1'b0, 32'h1000, 32'h0);

    // Reset during the first BUSY cycle of a write: response and write both vanish.
    @(negedge clk);
    writeFlag = 1'b1;
    addressIn = 32'h8;
    dataOut   = 32'h55;
    @(negedge clk);
    rst       = 1'b1;
    writeFlag = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    last_rd = '0;
    chk("midreset_ready", {31'd0, memReady}, 32'd0);
    chk("midreset_rdata", memoryDataIn, 32'd0);
    chk("midreset_err", {30'd0, memErr}, 32'd0);
    ready_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (memReady) ready_seen++;
    end
    chk("midreset_no_resp", ready_seen, 0);
    do_req(1'b1, 1'b0, 32'h8, 32'h0);

    for (int unsigned i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = $urandom_range(0, 2);
      a  = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      do_req(op != 1, op != 0, a, $urandom);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
